param_fifo: RTL
===============

// Module: param_fifo
// PURPOSE
//   Parametrised synchronous FIFO; successor to the fixed 8-bit front-panel FIFO.
//   Adds configurable width and depth, an occupancy count, programmable
//   almost-full/almost-empty flags, sticky overflow/underflow errors and a
//   show-ahead (first-word-fall-through) mode.
//   Driven by debounced single-cycle insert/remove/flush pulses; data_out feeds
//   the display driver.
// PARAMETERS
//   WIDTH      8  data word width in bits (>=1)
//   DEPTH      8  number of entries; power of two, >=2
//   AF_LEVEL   6  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL   2  almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//   SHOWAHEAD  0  0: data_out registered on remove; 1: data_out always shows head
// PORTS
//   ck            in   1                  system clock, rising edge
//   reset         in   1                  asynchronous, active-low reset
//   flush         in   1                  empty the FIFO (one-cycle pulse)
//   insert        in   1                  write data_in this cycle
//   remove        in   1                  pop head entry this cycle
//   err_clear     in   1                  clear sticky overflow/underflow
//   data_in       in   WIDTH              write data
//   data_out      out  WIDTH              read data, see BEHAVIOUR
//   full          out  1                  count == DEPTH
//   empty         out  1                  count == 0
//   almost_full   out  1                  count >= AF_LEVEL
//   almost_empty  out  1                  count <= AE_LEVEL
//   count         out  $clog2(DEPTH+1)    current occupancy
//   overflow      out  1                  sticky: insert attempted and refused
//   underflow     out  1                  sticky: remove attempted and refused
// BEHAVIOUR
// - Reset (reset=0, async): wr_ptr=rd_ptr=0, count=0, data_out=0, overflow=0,
//   underflow=0. Flags: empty=1, full=0, almost_empty=1, almost_full=0.
//   Memory contents are not reset.
// - Pointers: log2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally.
//   count is tracked separately; full/empty are derived from count only.
// - Priority per cycle: flush > {insert, remove}.
//   Flush: pointers and count go to 0, data_out goes to 0; the flush wins over a
//   same-cycle insert/remove, which are dropped without setting error flags.
// - insert while full and remove=0: write dropped, overflow<=1.
//   remove while empty: pop dropped, underflow<=1.
//   A same-cycle insert is still accepted (count 0 -> 1).
// - insert & remove while full: both performed; count stays DEPTH; the
//   overwrite targets the slot being vacated.
// - insert & remove with 0 < count < DEPTH: both performed, count unchanged.
// - err_clear clears overflow/underflow next edge.
//   If a new error occurs in the same cycle, the set wins.
// - SHOWAHEAD=0: on an accepted remove, data_out <= mem[rd_ptr] at that edge
//   (1-cycle latency). Otherwise data_out holds its value.
// - SHOWAHEAD=1: data_out = mem[rd_ptr] combinationally.
//   - When empty, data_out = 0.
//   - A word inserted into an empty FIFO appears on data_out the cycle after the
//     insert edge.
//   - remove pops the currently shown word.
// - All flags and count update on the same edge as the operation causing them;
//   no extra latency.
// - Inputs assumed synchronous to ck (debounced upstream); no internal
//   synchronisers.
// TESTING (DEPTH=8, WIDTH=8, AF=6, AE=2)
// - Reset, then insert 0x11..0x88 -> count 1..8; almost_full at 6; full at 8.
//   9th insert (0x99) -> overflow=1, count stays 8.
// - SHOWAHEAD=0: from full, 8 removes -> data_out 0x11..0x88 one cycle after
//   each edge. 9th remove -> underflow=1, data_out stays 0x88.
// - Fill 8, remove 3, insert 3 more (ptr wrap) -> drain order is correct across
//   the wrap; count reads 8 then 0.
// - Simultaneous insert+remove at full -> count 8, no overflow.
//   At empty -> count 1, underflow=1.
// - flush with insert=1 at count=5 -> count 0, empty=1, data_out 0, no error
//   flags. err_clear then clears the stickies.
// - SHOWAHEAD=1: insert 0xA5 into empty -> data_out 0xA5 next cycle.
//   Assert reset mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow errors and optional show-ahead output.
module param_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AF_LEVEL  = 6,
   parameter int AE_LEVEL  = 2,
   parameter int SHOWAHEAD = 0
) (
   input  logic                         ck,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         insert,
   input  logic                         remove,
   input  logic                         err_clear,
   input  logic [WIDTH-1:0]             data_in,
   output logic [WIDTH-1:0]             data_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             is_full, is_empty, wr_ok, rd_ok;

   always_comb begin
      is_full  = (count_q == CW'(DEPTH));
      is_empty = (count_q == '0);
      // A remove in the same cycle frees the slot, so a write at full is legal then.
      wr_ok    = insert & ~flush & (~is_full | remove);
      rd_ok    = remove & ~flush & ~is_empty;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      ovf_d = (ovf_q & ~err_clear) | (insert & ~flush & is_full & ~remove);
      unf_d = (unf_q & ~err_clear) | (remove & ~flush & is_empty);
   end

   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   always_ff @(posedge ck) begin
      if (wr_ok) mem_q[wr_ptr_q] <= data_in;
   end

   generate
      if (SHOWAHEAD == 0) begin : g_registered
         logic [WIDTH-1:0] dout_q, dout_d;

         always_comb begin
            dout_d = dout_q;
            if (flush)      dout_d = '0;
            else if (rd_ok) dout_d = mem_q[rd_ptr_q];
         end

         always_ff @(posedge ck or negedge reset) begin
            if (!reset) dout_q <= '0;
            else        dout_q <= dout_d;
         end

         assign data_out = dout_q;
      end else begin : g_showahead
         assign data_out = is_empty ? '0 : mem_q[rd_ptr_q];
      end
   endgenerate

   assign full         = is_full;
   assign empty        = is_empty;
   assign almost_full  = (count_q >= CW'(AF_LEVEL));
   assign almost_empty = (count_q <= CW'(AE_LEVEL));
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule
